// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  // Capture FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_t;

  // Period of the team's PWM generator, in clk cycles
  localparam int PWM_FRAME = 100_001;

  // Dead-line timeout: just under two generator frames without an edge
  localparam int CAPTURE_TIMEOUT = 2 * PWM_FRAME - 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the async PWM line, optionally deglitches it (PWM_CAPTURE_FILTER_EN), and emits rise/fall pulses.
// Latency: 3 clk from pin to rise/fall pulse, FILT_LEN+3 with the filter; both edges identical.
// Backpressure: none; free-running pipeline, pulses are single-cycle and never stall.
module pwm_edge_sync #(
  parameter int FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_rise;
  logic r_fall;
  logic w_acc;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("pwm_edge_sync: FILT_LEN must be at least 1");
  end

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FW-1:0] r_filt_cnt;
  logic          r_filt_lvl;

  // Accept a new level only after FILT_LEN consecutive samples agree on it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt_cnt <= '0;
      r_filt_lvl <= 1'b0;
    end else if (r_sync2 == r_filt_lvl) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
      r_filt_lvl <= r_sync2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_acc = r_filt_lvl;
`else
  assign w_acc = r_sync2;
`endif

  // Edge register: level and one-cycle rise/fall pulses on the accepted level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_acc;
      r_rise  <= w_acc & ~r_level;
      r_fall  <= ~w_acc & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of each PWM cycle in clk cycles; flags a dead line. Filter macro: PWM_CAPTURE_FILTER_EN.
// Latency: results and meas_valid register one clk after the completing rise pulse (rise pulse 3 / FILT_LEN+3 clk after pin).
// Backpressure: none; meas_valid is a one-cycle strobe, the consumer must take it when it fires.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = CAPTURE_TIMEOUT,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             line_level
);

  // A timeout wider than the counter can never be reached; the counter saturates instead.
  localparam bit               TMO_REACHABLE = ($clog2(TIMEOUT + 1) <= CNT_W);
  localparam logic [CNT_W-1:0] TMO_CNT       = CNT_W'(TIMEOUT);

  pwm_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_nosig;

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo;

  pwm_edge_sync #(
    .FILT_LEN (FILT_LEN)
  ) u_edge_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_tmo     = TMO_REACHABLE && (r_cnt == TMO_CNT);

  // Capture FSM: cnt counts cycles since the last accepted rise (or since arming);
  // an edge in the same cycle as a timeout always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_nosig  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hi    <= '0;
        r_nosig <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // the enable cycle itself counts toward the arm timeout
            r_state <= ARM;
            r_cnt   <= CNT_W'(1);
          end
          ARM: begin
            if (w_rise) begin
              r_state <= HIGH;
              r_cnt   <= CNT_W'(1);
              r_nosig <= 1'b0;
            end else if (w_tmo) begin
              r_nosig <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_hi    <= r_cnt;
              r_state <= LOW;
              r_cnt   <= w_cnt_inc;
            end else if (w_tmo) begin
              r_nosig <= 1'b1;
              r_cnt   <= '0;
              r_state <= ARM;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_period <= r_cnt;
              r_high   <= r_hi;
              r_valid  <= 1'b1;
              r_cnt    <= CNT_W'(1);
              r_state  <= HIGH;
            end else if (w_tmo) begin
              r_nosig <= 1'b1;
              r_cnt   <= '0;
              r_state <= ARM;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign period_cnt = r_period;
  assign high_cnt   = r_high;
  assign meas_valid = r_valid;
  assign no_signal  = r_nosig;
  assign line_level = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed/randomized bench for pwm_capture against a segment-list waveform model.
// Latency: the model only relies on the pin-to-pulse latency for the timeout checks.
// Backpressure: n/a.
module tb_pwm_capture;

  localparam int CNT_W = 32;
  localparam int TMO   = 1000;
  localparam int FILT  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT  = 3 + FILT;
  localparam int FMIN = FILT;
`else
  localparam int LAT  = 3;
  localparam int FMIN = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             no_signal;
  logic             line_level;

  int          n_pass   = 0;
  int          n_total  = 0;
  int          n_double = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_per = '0;
  logic [31:0] exp_hi  = '0;

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TMO),
    .FILT_LEN (FILT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .line_level (line_level)
  );

  // Record every result strobe and any back-to-back strobe
  always @(negedge clk) begin
    if (meas_valid) obs_q.push_back({period_cnt, high_cnt});
    if (meas_valid && prev_valid) n_double++;
    prev_valid = meas_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic seg(input logic lvl, input int n);
    pwm_in = lvl;
    cyc(n);
  endtask

  // A completed frame of high h and low l cycles reports period h+l, high h
  function automatic void expect_meas(input int h, input int l);
    exp_q.push_back({32'(h + l), 32'(h)});
    exp_per = 32'(h + l);
    exp_hi  = 32'(h);
  endfunction

  task automatic check_meas(input string tag);
    logic [63:0] o;
    logic [63:0] e;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_period"}, {32'd0, o[63:32]}, {32'd0, e[63:32]});
      check({tag, "_high"}, {32'd0, o[31:0]}, {32'd0, e[31:0]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int h;
    int l;
    rst_n  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    cyc(3);
    check("rst_period", period_cnt, 0);
    check("rst_high", high_cnt, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_nosig", no_signal, 0);
    check("rst_level", line_level, 0);
    rst_n = 1'b1;
    cyc(3);

    // Constant low line: dead-line flag exactly TMO cycles after enable
    en = 1'b1;
    cyc(TMO);
    check("low_nosig_early", no_signal, 0);
    cyc(1);
    check("low_nosig", no_signal, 1);
    check("low_level", line_level, 0);
    check_meas("low_line");

    // Random frames: first rise arms, each later rise reports the frame before it
    seg(1'b0, 10);
    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(300, FMIN));
      l = int'($urandom_range(300, FMIN));
      seg(1'b1, h);
      seg(1'b0, l);
      expect_meas(h, l);
    end

    // Final rise then line stuck high: timeout TMO cycles after the rise pulse
    pwm_in = 1'b1;
    cyc(TMO + LAT);
    check_meas("frames");
    check("stuck_nosig_early", no_signal, 0);
    cyc(1);
    check("stuck_nosig", no_signal, 1);
    check("stuck_period_held", period_cnt, exp_per);
    check("stuck_high_held", high_cnt, exp_hi);

    // New waveform after timeout: first report on its second rise
    seg(1'b0, 30);
    h = int'($urandom_range(200, FMIN));
    l = int'($urandom_range(200, FMIN));
    seg(1'b1, h);
    seg(1'b0, l);
    expect_meas(h, l);
    seg(1'b1, 20);
    check_meas("rearm");
    check("rearm_nosig", no_signal, 0);

    // Enable dropped mid-HIGH: broken frame discarded, results held
    en = 1'b0;
    cyc(5);
    check_meas("en_drop");
    check("en_drop_period", period_cnt, exp_per);
    check("en_drop_high", high_cnt, exp_hi);
    check("en_drop_nosig", no_signal, 0);
    en = 1'b1;
    seg(1'b1, 5);
    seg(1'b0, 30);
    h = int'($urandom_range(200, FMIN));
    l = int'($urandom_range(200, FMIN));
    seg(1'b1, h);
    seg(1'b0, l);
    expect_meas(h, l);
    seg(1'b1, 20);
    check_meas("en_restore");

    // Two-cycle low glitch inside a 500-cycle high pulse
    en     = 1'b0;
    pwm_in = 1'b0;
    cyc(LAT + 5);
    en = 1'b1;
    seg(1'b0, 40);
    seg(1'b1, 200);
    seg(1'b0, 2);
    seg(1'b1, 298);
    seg(1'b0, 300);
`ifdef PWM_CAPTURE_FILTER_EN
    expect_meas(500, 300);
`else
    expect_meas(200, 2);
    expect_meas(298, 300);
`endif
    seg(1'b1, 50);
    check_meas("glitch");

    // Reset in the middle of LOW: outputs clear immediately
    seg(1'b0, 60);
    rst_n = 1'b0;
    #1;
    check("midrst_period", period_cnt, 0);
    check("midrst_high", high_cnt, 0);
    check("midrst_valid", meas_valid, 0);
    check("midrst_nosig", no_signal, 0);
    check("midrst_level", line_level, 0);
    cyc(2);
    rst_n = 1'b1;
    seg(1'b0, 20);
    h = int'($urandom_range(200, FMIN));
    l = int'($urandom_range(200, FMIN));
    seg(1'b1, h);
    seg(1'b0, l);
    expect_meas(h, l);
    seg(1'b1, 20);
    check_meas("post_reset");

    check("valid_back_to_back", 64'(n_double), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM measurement block, the receive-side counterpart of the team's PWM generator. It samples an external PWM line asynchronous to clk and measures the period and high time of every complete cycle in clk cycles. It publishes each result with a one-cycle valid strobe for the AXI register wrapper. It also flags a line that has stopped toggling.

## Interface
Parameters:
- CNT_W, 32: width of the internal counter and of both result outputs.
- TIMEOUT, 200_000: count of cycles without an accepted edge that declares the line dead.
- FILT_LEN, 4: number of stable samples the glitch filter requires. Used only with the filter macro.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: capture enable. Level-sensitive.
- pwm_in, input, 1: PWM line, asynchronous to clk.
- period_cnt, output, CNT_W: last measured period in clk cycles.
- high_cnt, output, CNT_W: last measured high time in clk cycles.
- meas_valid, output, 1: one-cycle strobe; period_cnt and high_cnt were updated in this same cycle.
- no_signal, output, 1: level; timeout has expired since the last accepted edge.
- line_level, output, 1: filtered, synchronized line level.

## Operation
- Input path: pwm_in passes through a 2-flop synchronizer, then the optional filter, then an edge register. rise and fall are single-cycle pulses on the accepted level.
- Internal counter cnt is CNT_W wide and saturates at all-ones; it never wraps. Internal register hi holds the high time of the cycle in progress.
- States:
  - IDLE: entered when en=0. cnt=0, hi=0. Goes to ARM when en=1.
  - ARM: waits for rise. Any fall is ignored. On rise: cnt<=1, go to HIGH.
  - HIGH: cnt increments each cycle. On fall: hi<=cnt, go to LOW.
  - LOW: cnt increments each cycle. On rise: period_cnt<=cnt, high_cnt<=hi, meas_valid<=1, cnt<=1, go to HIGH.
- Measurement semantics: the first rise only arms the block. Every later rise completes one measurement.
- Timeout: applies in HIGH or LOW when cnt reaches TIMEOUT with no edge.
  - Sets no_signal=1 and goes to ARM.
  - No meas_valid; period_cnt and high_cnt hold their previous values.
  - The next rise clears no_signal and starts a fresh, unreported measurement.
- Timeout in ARM: cnt also counts in ARM, and no_signal asserts after TIMEOUT cycles without a rise. cnt resets to 0 on each timeout.
- en deasserted in any state:
  - The next cycle goes to IDLE. cnt and hi clear, no_signal clears, and any partial measurement is discarded.
  - period_cnt and high_cnt hold their values.
- Simultaneous rise and timeout in one cycle: the edge wins, and no_signal is not set.
- Saturation: if cnt saturates, the results report all-ones. This is reachable only when TIMEOUT is at least 2^CNT_W.
- Reset values: period_cnt=0, high_cnt=0, meas_valid=0, no_signal=0, line_level=0. State is IDLE and the synchronizer flops are 0.

## Timing
- Edge latency: 3 clk from a pwm_in transition to the rise/fall pulse without the filter, FILT_LEN+3 with it.
- The latency is identical for both edges, so measured counts carry no bias. Quantization is ±1 cycle per edge for asynchronous input.
- Result latency: meas_valid, period_cnt and high_cnt update on the clock edge after rise is seen in LOW.
- meas_valid is never high two consecutive cycles.
- Minimum measurable pulse: 1 cycle high or low without the filter, FILT_LEN cycles with it. Shorter pulses are lost or merged.

## Configuration
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined: the accepted level changes only after the synchronized input has held a new value for FILT_LEN consecutive cycles. Shorter glitches are rejected entirely.
- Undefined: the synchronized input is the accepted level, and FILT_LEN is unused.

## Structure
- Shared package pwm_pkg holds:
  - state encoding constants IDLE=2'd0, ARM=2'd1, HIGH=2'd2, LOW=2'd3;
  - default PWM_FRAME=100_001, the generator's period;
  - default CAPTURE_TIMEOUT.
- One sub-module, pwm_edge_sync: synchronizer, optional filter and edge register. Outputs level, rise and fall.
- The FSM, counters and result registers stay in pwm_capture.

## Test plan
- Generator-shaped input, period 100_001 cycles, high time 30_000, en=1: from the second rise on, meas_valid pulses once per frame with period_cnt=100_001 and high_cnt=30_000.
- High time 0, constant low line: no meas_valid. no_signal=1 exactly TIMEOUT cycles after en rises. line_level=0.
- Constant high after one rise: no_signal=1 TIMEOUT cycles after the rise and results unchanged. A new waveform then gives its first meas_valid on its second rise.
- en dropped mid-HIGH then restored: no meas_valid for the broken frame, old results held, next valid result is correct.
- Filter macro defined, FILT_LEN=4, 2-cycle low glitch inside a 500-cycle high pulse: high_cnt=500 and a single measurement. Without the macro the glitch produces a measurement with high_cnt shorter than 500.
- rst_n asserted mid-LOW: all outputs return to reset values at once. Measurement restarts from ARM after release.
